// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low matrix keypad scanner: column rotation, tick-based debounce,
// single-key encoding with a one-clock valid strobe and multi-key suppression.
module keypad_scan_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

    state_t             r_state;
    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_s;
    logic [DIV_W-1:0]   r_div;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic [1:0]         r_col_idx;
    logic [3:0]         r_pattern;
    logic [3:0]         r_col;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_key_held;
    logic               r_multi_key;

    logic               w_tick;
    logic [DEB_W-1:0]   w_deb_inc;
    logic               w_deb_done;
    logic [1:0]         w_col_adv_idx;
    logic [3:0]         w_col_adv;
    logic [3:0]         w_accept_pat;
    logic [2:0]         w_zero_cnt;
    logic [1:0]         w_zero_row;
    logic               w_accept;

    // NOTE: every register below uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'b1111;
            r_row_s    <= 4'b1111;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + DIV_W'(1);
    end

    assign w_tick        = (r_div == DIV_LAST);
    assign w_deb_inc     = r_deb_cnt + DEB_W'(1);
    assign w_deb_done    = (w_deb_inc == DEB_DONE);
    assign w_col_adv_idx = r_col_idx + 2'd1;
    assign w_col_adv     = ~(4'b0001 << w_col_adv_idx);
    assign w_accept_pat  = (r_state == SCAN) ? r_row_s : r_pattern;

    always_comb begin
        w_zero_cnt = '0;
        w_zero_row = '0;
        for (int i = 0; i < 4; i++) begin
            if (!w_accept_pat[i]) begin
                w_zero_cnt = w_zero_cnt + 3'd1;
                w_zero_row = 2'(i);
            end
        end
    end

    assign w_accept = w_tick &&
        (((r_state == SCAN) && (r_row_s != 4'b1111) && (DEBOUNCE_TICKS == 1)) ||
         ((r_state == DEBOUNCE) && (r_row_s == r_pattern) && w_deb_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_deb_cnt   <= '0;
            r_col_idx   <= '0;
            r_pattern   <= 4'b1111;
            r_col       <= 4'b1110;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_multi_key <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (r_row_s == 4'b1111) begin
                            r_col_idx <= w_col_adv_idx;
                            r_col     <= w_col_adv;
                        end else begin
                            r_pattern <= r_row_s;
                            r_state   <= DEBOUNCE;
                            r_deb_cnt <= DEB_W'(1);
                        end
                    end
                    DEBOUNCE: begin
                        if (r_row_s == r_pattern) begin
                            r_deb_cnt <= w_deb_inc;
                        end else begin
                            r_state   <= SCAN;
                            r_deb_cnt <= '0;
                            r_col_idx <= w_col_adv_idx;
                            r_col     <= w_col_adv;
                        end
                    end
                    PRESSED: begin
                        if (r_row_s != 4'b1111) begin
                            r_deb_cnt <= '0;
                        end else if (w_deb_done) begin
                            r_state     <= SCAN;
                            r_deb_cnt   <= '0;
                            r_key_held  <= 1'b0;
                            r_multi_key <= 1'b0;
                            r_col_idx   <= w_col_adv_idx;
                            r_col       <= w_col_adv;
                        end else begin
                            r_deb_cnt <= w_deb_inc;
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
            // Acceptance is placed last so it overrides the plain counting above.
            if (w_accept) begin
                r_state   <= PRESSED;
                r_deb_cnt <= '0;
                if (w_zero_cnt == 3'd1) begin
                    r_key_code  <= {w_zero_row, r_col_idx};
                    r_key_valid <= 1'b1;
                    r_key_held  <= 1'b1;
                end else begin
                    r_multi_key <= 1'b1;
                end
            end
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign multi_key = r_multi_key;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a keypad matrix model drives the rows, a scoreboard
// queue holds expected key codes and a monitor checks every key_valid pulse.
module tb_keypad_scan_encoder;
    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    logic [15:0] pressed = '0;
    logic [3:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    keypad_scan_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    always #5 clk = ~clk;

    // A row reads low only when one of its pressed keys sits in the driven column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_key_valid", 32'(key_valid), 32'd0);
            end else begin
                logic [3:0] exp_code;
                exp_code = exp_q.pop_front();
                check("key_code_at_valid", 32'(key_code), 32'(exp_code));
                check("held_with_valid", 32'(key_held), 32'd1);
            end
        end
    end

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r*4+c] = v;
    endtask

    task automatic wait_held(input logic lvl, input int budget, input string name);
        int k = 0;
        while (key_held !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(key_held), 32'(lvl));
    endtask

    task automatic wait_multi(input logic lvl, input int budget, input string name);
        int k = 0;
        while (multi_key !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(multi_key), 32'(lvl));
    endtask

    // Returns at the first negedge after col switches to target.
    task automatic wait_col_enter(input logic [3:0] target, input int budget, input string name);
        logic [3:0] prev;
        logic       found = 1'b0;
        int         k = 0;
        while (!found && k < budget) begin
            prev = col;
            @(negedge clk);
            k++;
            found = (col == target) && (prev != target);
        end
        check(name, {27'd0, found, col}, {27'd0, 1'b1, target});
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_col", 32'(col), 32'hE);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_multi_key", 32'(multi_key), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan rotation
        repeat (3) @(negedge clk);
        check("scan_dwell", 32'(col), 32'hE);
        @(negedge clk);
        check("scan_col1", 32'(col), 32'hD);
        repeat (4) @(negedge clk);
        check("scan_col2", 32'(col), 32'hB);
        repeat (4) @(negedge clk);
        check("scan_col3", 32'(col), 32'h7);
        repeat (4) @(negedge clk);
        check("scan_wrap", 32'(col), 32'hE);

        // Clean press of key (2,1)
        wait_col_enter(4'b1101, 40, "t2_enter_col1");
        set_key(2, 1, 1'b1);
        exp_q.push_back(4'd9);
        repeat (40) @(negedge clk);
        check("t2_held", 32'(key_held), 32'd1);
        check("t2_no_multi", 32'(multi_key), 32'd0);
        set_key(2, 1, 1'b0);
        repeat (8) @(negedge clk);
        check("t2_held_during_release_debounce", 32'(key_held), 32'd1);
        wait_held(1'b0, 20, "t2_release");
        check("t2_col_after_release", 32'(col), 32'hB);
        check("t2_code_kept", 32'(key_code), 32'd9);

        // Bouncy press of key (0,3): two ticks low, then high
        for (int b = 0; b < 3; b++) begin
            wait_col_enter(4'b0111, 40, "t3_enter_col3");
            set_key(0, 3, 1'b1);
            repeat (4) @(negedge clk);
            check("t3_col_frozen", 32'(col), 32'h7);
            repeat (4) @(negedge clk);
            set_key(0, 3, 1'b0);
            repeat (4) @(negedge clk);
            check("t3_abandon_col", 32'(col), 32'hE);
            check("t3_not_held", 32'(key_held), 32'd0);
        end
        wait_col_enter(4'b0111, 40, "t3_enter_col3_stable");
        set_key(0, 3, 1'b1);
        exp_q.push_back(4'd3);
        wait_held(1'b1, 30, "t3_stable_accept");
        repeat (10) @(negedge clk);
        set_key(0, 3, 1'b0);
        wait_held(1'b0, 30, "t3_release");
        check("t3_code_kept", 32'(key_code), 32'd3);

        // Two keys in column 2
        wait_col_enter(4'b1011, 40, "t4_enter_col2");
        set_key(0, 2, 1'b1);
        set_key(3, 2, 1'b1);
        wait_multi(1'b1, 30, "t4_multi_set");
        check("t4_code_unchanged", 32'(key_code), 32'd3);
        check("t4_not_held", 32'(key_held), 32'd0);
        repeat (10) @(negedge clk);
        set_key(0, 2, 1'b0);
        set_key(3, 2, 1'b0);
        wait_multi(1'b0, 30, "t4_multi_clear");
        check("t4_col_after_release", 32'(col), 32'h7);

        // Long hold of key (1,0) with a short release glitch
        wait_col_enter(4'b1110, 40, "t5_enter_col0");
        set_key(1, 0, 1'b1);
        exp_q.push_back(4'd4);
        wait_held(1'b1, 30, "t5_accept");
        repeat (400) @(negedge clk);
        set_key(1, 0, 1'b0);
        repeat (6) @(negedge clk);
        set_key(1, 0, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_glitch_held", 32'(key_held), 32'd1);
        check("t5_code", 32'(key_code), 32'd4);
        set_key(1, 0, 1'b0);
        wait_held(1'b0, 30, "t5_release");

        // Reset while key (3,3) is held
        wait_col_enter(4'b0111, 40, "t6_enter_col3");
        set_key(3, 3, 1'b1);
        exp_q.push_back(4'd15);
        wait_held(1'b1, 30, "t6_accept");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_col", 32'(col), 32'hE);
        check("t6_rst_code", 32'(key_code), 32'h0);
        check("t6_rst_held", 32'(key_held), 32'h0);
        check("t6_rst_multi", 32'(multi_key), 32'h0);
        check("t6_rst_valid", 32'(key_valid), 32'h0);
        exp_q.push_back(4'd15);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_held(1'b1, 60, "t6_fresh_accept");
        repeat (10) @(negedge clk);
        set_key(3, 3, 1'b0);
        wait_held(1'b0, 30, "t6_release");
        repeat (10) @(negedge clk);
        check("pending_expected_valids", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
